keccak_sponge_ctrl: RTL

- Sequences the round-iterative Keccak-f[1600] permutation core as a SHAKE128/SHAKE256 sponge for the Kyber768 XOF and PRF paths.
- Absorbs one message of at most MAX_MSG_BYTES bytes and applies SHAKE padding.
- Runs the permutation, then streams N rate-sized squeeze blocks to a consumer over a valid/ready handshake.
- Owns the 1600-bit state register; the permutation core is a slave started by a pulse, completing with a valid pulse.

---
 rtl/keccak_pkg.sv | 24 ++
 rtl/keccak_pad_absorb.sv | 30 +++
 rtl/keccak_sponge_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak sponge controller.
package keccak_pkg;

    localparam int STATE_W       = 1600;
    localparam int RATE128_BYTES = 168;
    localparam int RATE256_BYTES = 136;
    // Output block is wide enough for the larger (SHAKE128) rate.
    localparam int OUT_W         = 8 * RATE128_BYTES;

    localparam logic [7:0] SHAKE_DSEP = 8'h1F;
    localparam logic [7:0] PAD_LAST   = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        PERM,
        OUT
    } sponge_state_e;

    // Rate in bytes for the selected SHAKE variant (0 = SHAKE128, 1 = SHAKE256).
    function automatic int rate_bytes(input logic mode);
        return mode ? RATE256_BYTES : RATE128_BYTES;
    endfunction

endpackage

// File: rtl/keccak_pad_absorb.sv
// Builds the padded single-block initial sponge state from a short message:
// message bytes, domain separator 0x1F after the message, 0x80 in the last rate byte.
module keccak_pad_absorb
    import keccak_pkg::*;
#(
    parameter int MAX_MSG_BYTES = 64
) (
    input  logic                       mode,
    input  logic [8*MAX_MSG_BYTES-1:0] msg,
    input  logic [6:0]                 msg_len,
    output logic [STATE_W-1:0]         state_init
);

    logic [7:0] len_c;

    // Oversized lengths are clamped to the message buffer size.
    assign len_c = (int'(msg_len) > MAX_MSG_BYTES) ? 8'(MAX_MSG_BYTES) : {1'b0, msg_len};

    // Copy live message bytes, then XOR in both padding bytes; when they land on
    // the same byte (message fills rate-1 bytes) the XOR merges them into 0x9F.
    always_comb begin
        state_init = '0;
        for (int k = 0; k < MAX_MSG_BYTES; k++) begin
            if (k < int'(len_c)) state_init[8*k +: 8] = msg[8*k +: 8];
        end
        state_init[8*int'(len_c) +: 8]         ^= SHAKE_DSEP;
        state_init[8*(rate_bytes(mode)-1) +: 8] ^= PAD_LAST;
    end

endmodule

// File: rtl/keccak_sponge_ctrl.sv
// SHAKE128/256 sponge sequencer around an external round-iterative Keccak-f core.
// Single-block absorb, then N squeeze blocks over valid/ready.
// Optional: define KECCAK_SPONGE_PERF_EN to add the perf_cycles busy-cycle counter.
module keccak_sponge_ctrl
    import keccak_pkg::*;
#(
    parameter int MAX_MSG_BYTES = 64,
    parameter int BLK_CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode,
    input  logic [8*MAX_MSG_BYTES-1:0] msg,
    input  logic [6:0]                 msg_len,
    input  logic [BLK_CNT_W-1:0]       num_blocks,
    input  logic                       abort,
    output logic                       busy,
    output logic [OUT_W-1:0]           out_block,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       perm_start,
    output logic [STATE_W-1:0]         perm_state_in,
    input  logic [STATE_W-1:0]         perm_state_out,
    input  logic                       perm_valid
`ifdef KECCAK_SPONGE_PERF_EN
    ,
    output logic [31:0]                perf_cycles
`endif
);

    sponge_state_e          state_q, state_d;
    logic [STATE_W-1:0]     st_q, pad_state;
    logic [BLK_CNT_W-1:0]   cnt_q;
    logic                   mode_q, perm_start_q;
    logic                   load, capture, handshake;

    keccak_pad_absorb #(.MAX_MSG_BYTES(MAX_MSG_BYTES)) u_pad (
        .mode       (mode),
        .msg        (msg),
        .msg_len    (msg_len),
        .state_init (pad_state)
    );

    // Next-state decode; abort always wins over start, perm_valid and out_ready.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state_q)
            IDLE: if (start && !abort) begin
                load    = 1'b1;
                state_d = PERM;
            end
            PERM: if (abort) begin
                state_d = IDLE;
            end else if (perm_valid) begin
                capture = 1'b1;
                state_d = OUT;
            end
            OUT: if (abort) begin
                state_d = IDLE;
            end else if (out_ready) begin
                handshake = 1'b1;
                state_d   = (cnt_q == BLK_CNT_W'(1)) ? IDLE : PERM;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, sponge state, block counter and the perm_start pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            st_q         <= '0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            perm_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            // Pulse only on entry to PERM, so a stay in PERM never re-fires.
            perm_start_q <= (state_d == PERM) && (state_q != PERM);
            if (load) begin
                st_q   <= pad_state;
                mode_q <= mode;
                cnt_q  <= (num_blocks == '0) ? BLK_CNT_W'(1) : num_blocks;
            end else begin
                if (capture)   st_q  <= perm_state_out;
                if (handshake) cnt_q <= cnt_q - BLK_CNT_W'(1);
            end
        end
    end

    // Squeeze view: rate bytes only; SHAKE256 zeroes bytes 136..167.
    always_comb begin
        out_block = st_q[OUT_W-1:0];
        if (mode_q) out_block[OUT_W-1:8*RATE256_BYTES] = '0;
    end

    assign busy          = (state_q != IDLE);
    assign out_valid     = (state_q == OUT);
    assign out_last      = out_valid && (cnt_q == BLK_CNT_W'(1));
    assign perm_start    = perm_start_q;
    assign perm_state_in = st_q;

`ifdef KECCAK_SPONGE_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter: cleared on accepted start, saturating, frozen in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (load) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
